reset_sequencer: RTL
====================

Name: reset_sequencer

Overview:
Parametrised successor to the single-output reset conditioner. Drives CHANNELS active-high reset outputs and releases them one at a time, in index order, after a minimum hold period. Each release waits for that channel's ready acknowledge or a timeout. Per-channel asynchronous reset requests re-assert that channel and every higher-index channel, then re-run the sequence from that point. Sits at the top level between the board reset and the clock-domain or peripheral resets (PLL, DRAM PHY, core logic).

Parameters:
CHANNELS, 4, number of sequenced reset outputs (1..16)
SYNC_STAGES, 2, synchroniser depth for each req_in bit (>=2)
HOLD_CYCLES, 16, cycles all requested resets are held before the first release (>=1)
GAP_CYCLES, 8, settle cycles after each channel release (>=1)
TIMEOUT_CYCLES, 1024, maximum cycles to wait for ready_in per channel (>=1)

Ports:
clk  in  1  system clock
rst  in  1  master reset; one clock; reset is synchronous and active-high
req_in  in  CHANNELS  asynchronous per-channel reset request, active-high, level
ready_in  in  CHANNELS  per-channel "out of reset and ready", synchronous to clk
rst_out  out  CHANNELS  sequenced resets, active-high, driven directly from flops
seq_done  out  1  high only while the FSM is in RUN
timeout_err  out  CHANNELS  sticky flag: the channel's ready_in timed out

Behaviour:
- rst=1: rst_out=all 1s, seq_done=0, timeout_err=0, synchronisers=0, ch=0, counter=0, state=HOLD. rst overrides everything, including mid-sequence.
- Counter width = clog2(max(HOLD,GAP,TIMEOUT)+1). The counter saturates and never wraps.
- States:
  - HOLD: counts while no synchronised request is high. Any high request clears the counter, so the hold is stretched until HOLD_CYCLES quiet cycles have passed. Exits to RELEASE.
  - RELEASE (1 cycle): rst_out[ch]<=0, counter<=0, next state WAIT.
  - WAIT: ready_in[ch]=1 moves to GAP next cycle. If ready_in[ch] is already high on WAIT entry, GAP follows after one cycle. If the counter reaches TIMEOUT_CYCLES-1 without ready: timeout_err[ch]<=1, then GAP. The sequence is never stalled.
  - GAP: lasts GAP_CYCLES. Then, if ch==CHANNELS-1, go to RUN; else ch<=ch+1 and go to RELEASE.
  - RUN: seq_done=1. A drop on ready_in is ignored.
- Request handling, any state except under rst:
  - Let j be the lowest index with a synchronised request high.
  - Next cycle: rst_out[k]<=1 for all k>=j; ch<=min(j,ch); counter<=0; state<=HOLD.
  - Channels below the new ch keep their current value.
  - When several requests arrive together, the lowest index wins.
- Timing from the first cycle with rst=0 (cycle 0):
  - HOLD occupies cycles 0..HOLD_CYCLES-1.
  - rst_out[0] falls at cycle HOLD_CYCLES+1.
  - With immediate ready, channel pitch is GAP_CYCLES+2.
- Request latency: req_in edge to rst_out assertion is SYNC_STAGES+1 cycles.
- timeout_err is cleared only by rst.

Optional Feature:
RESET_SEQ_READY_EN
- Defined: WAIT state, ready_in handshake and timeout behave as described above.
- Undefined: RELEASE goes straight to GAP; ready_in is ignored; timeout_err is tied to 0; channel pitch is GAP_CYCLES+1.

Decomposition:
- Package reset_seq_pkg holds:
  - the state enum (HOLD, RELEASE, WAIT, GAP, RUN) as a 3-bit encoding
  - a counter-width function
  - the default constants
- One natural sub-module, reset_req_sync: a SYNC_STAGES-deep 2-FF-style synchroniser with synchronous clear. It is instantiated CHANNELS wide.

Test Plan:
- Defaults, rst held 5 cycles, ready_in=4'hF:
  - rst_out bits fall at cycles 17, 27, 37, 47 after rst release.
  - seq_done=1 from cycle 56.
  - timeout_err=0.
- ready_in[2] tied 0:
  - timeout_err=4'b0100 after 1024 WAIT cycles.
  - Channel 3 is still released.
  - seq_done=1 afterwards.
- In RUN, req_in[1] pulses high for 3 cycles:
  - 3 cycles after the edge, rst_out=4'b1110 and seq_done=0.
  - HOLD lasts 16 quiet cycles, then channels 1..3 are re-released at pitch 10.
- req_in[3] and req_in[1] rise together while in GAP for ch=2:
  - rst_out=4'b1110.
  - The restart begins from channel 1.
- rst asserted mid-GAP, ch=2, with timeout_err=4'b0001:
  - Next cycle: rst_out=4'hF, timeout_err=0, seq_done=0.
  - The full sequence replays.
- Built without RESET_SEQ_READY_EN, ready_in=0:
  - rst_out bits fall at cycles 17, 26, 35, 44.
  - timeout_err stays 0.

Source files
------------

// File: rtl/reset_seq_pkg.sv
// Shared types and defaults for the reset sequencer: FSM state encoding,
// default parameter values and the counter-width helper.
package reset_seq_pkg;

   typedef enum logic [2:0] {
      HOLD    = 3'd0,
      RELEASE = 3'd1,
      WAIT    = 3'd2,
      GAP     = 3'd3,
      RUN     = 3'd4
   } seq_state_e;

   localparam int unsigned DEF_CHANNELS       = 4;
   localparam int unsigned DEF_SYNC_STAGES    = 2;
   localparam int unsigned DEF_HOLD_CYCLES    = 16;
   localparam int unsigned DEF_GAP_CYCLES     = 8;
   localparam int unsigned DEF_TIMEOUT_CYCLES = 1024;

   // One shared counter must hold the largest of the three terminal counts.
   function automatic int unsigned cnt_width(input int unsigned hold_c,
                                             input int unsigned gap_c,
                                             input int unsigned to_c);
      int unsigned m;
      m = hold_c;
      if (gap_c > m) m = gap_c;
      if (to_c > m) m = to_c;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/reset_req_sync.sv
// Multi-stage synchroniser for one asynchronous reset-request bit,
// cleared synchronously by the master reset.
module reset_req_sync #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_d,
   output logic o_q
);

   logic [SYNC_STAGES-1:0] r_sync;

   always_ff @(posedge i_clk) begin
      if (i_rst) r_sync <= '0;
      else       r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
   end

   assign o_q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Sequenced multi-channel reset release with per-channel re-request.
// Build option RESET_SEQ_READY_EN enables the ready_in handshake and timeout.
module reset_sequencer
   import reset_seq_pkg::*;
#(
   parameter int unsigned CHANNELS       = DEF_CHANNELS,
   parameter int unsigned SYNC_STAGES    = DEF_SYNC_STAGES,
   parameter int unsigned HOLD_CYCLES    = DEF_HOLD_CYCLES,
   parameter int unsigned GAP_CYCLES     = DEF_GAP_CYCLES,
   parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [CHANNELS-1:0] req_in,
   input  logic [CHANNELS-1:0] ready_in,
   output logic [CHANNELS-1:0] rst_out,
   output logic                seq_done,
   output logic [CHANNELS-1:0] timeout_err
);

   localparam int unsigned CNT_W = cnt_width(HOLD_CYCLES, GAP_CYCLES, TIMEOUT_CYCLES);
   localparam int unsigned CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
   localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(CHANNELS - 1);
`ifdef RESET_SEQ_READY_EN
   localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

   seq_state_e          r_state, w_state_nxt;
   logic [CH_W-1:0]     r_ch, w_ch_nxt;
   logic [CNT_W-1:0]    r_cnt, w_cnt_nxt, w_cnt_inc;
   logic [CHANNELS-1:0] r_rst_out, w_rst_nxt;
   logic [CHANNELS-1:0] r_timeout, w_timeout_nxt;

   logic [CHANNELS-1:0] w_req_sync;
   logic [CHANNELS-1:0] w_req_mask;
   logic                w_req_any;
   logic [CH_W-1:0]     w_req_idx;

   for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_sync
      reset_req_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
         .i_clk (clk),
         .i_rst (rst),
         .i_d   (req_in[gi]),
         .o_q   (w_req_sync[gi])
      );
   end

   // Lowest requesting index wins; the mask covers it and every channel above.
   always_comb begin
      w_req_any  = 1'b0;
      w_req_idx  = '0;
      w_req_mask = '0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
         if (w_req_sync[i] && !w_req_any) begin
            w_req_any = 1'b1;
            w_req_idx = CH_W'(i);
         end
         w_req_mask[i] = w_req_any;
      end
   end

   assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;

   always_comb begin
      w_state_nxt   = r_state;
      w_ch_nxt      = r_ch;
      w_cnt_nxt     = w_cnt_inc;
      w_rst_nxt     = r_rst_out;
      w_timeout_nxt = r_timeout;
      if (w_req_any) begin
         w_rst_nxt   = r_rst_out | w_req_mask;
         w_ch_nxt    = (w_req_idx < r_ch) ? w_req_idx : r_ch;
         w_cnt_nxt   = '0;
         w_state_nxt = HOLD;
      end else begin
         case (r_state)
            HOLD: begin
               if (r_cnt == HOLD_LAST) begin
                  w_state_nxt = RELEASE;
                  w_cnt_nxt   = '0;
               end
            end
            RELEASE: begin
               w_rst_nxt[r_ch] = 1'b0;
               w_cnt_nxt       = '0;
`ifdef RESET_SEQ_READY_EN
               w_state_nxt     = WAIT;
`else
               w_state_nxt     = GAP;
`endif
            end
`ifdef RESET_SEQ_READY_EN
            WAIT: begin
               if (ready_in[r_ch]) begin
                  w_state_nxt = GAP;
                  w_cnt_nxt   = '0;
               end else if (r_cnt == TO_LAST) begin
                  w_timeout_nxt[r_ch] = 1'b1;
                  w_state_nxt         = GAP;
                  w_cnt_nxt           = '0;
               end
            end
`endif
            GAP: begin
               if (r_cnt == GAP_LAST) begin
                  w_cnt_nxt = '0;
                  if (r_ch == CH_LAST) begin
                     w_state_nxt = RUN;
                  end else begin
                     w_ch_nxt    = r_ch + 1'b1;
                     w_state_nxt = RELEASE;
                  end
               end
            end
            RUN: begin
               w_state_nxt = RUN;
            end
            default: begin
               w_state_nxt = HOLD;
               w_cnt_nxt   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= HOLD;
         r_ch      <= '0;
         r_cnt     <= '0;
         r_rst_out <= '1;
         r_timeout <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_ch      <= w_ch_nxt;
         r_cnt     <= w_cnt_nxt;
         r_rst_out <= w_rst_nxt;
         r_timeout <= w_timeout_nxt;
      end
   end

   assign rst_out  = r_rst_out;
   assign seq_done = (r_state == RUN);

`ifdef RESET_SEQ_READY_EN
   assign timeout_err = r_timeout;
`else
   logic w_unused_ready;
   logic w_unused_timeout;
   assign w_unused_ready   = ^ready_in;
   assign w_unused_timeout = ^r_timeout;
   assign timeout_err      = '0;
`endif

endmodule
